// File: rtl/ysyx_22050039_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encoding, reset PC and
// instruction width.
package ysyx_22050039_pkg;

   localparam int          INST_W           = 32;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/ysyx_22050039_fetch_ctrl_reg.sv
// Generic write-enabled register with asynchronous active-low reset.
module ysyx_22050039_Reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wen,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   o_dout <= RESET_VAL;
      else if (i_wen) o_dout <= i_din;
   end

endmodule

// File: rtl/ysyx_22050039_fetch_ctrl.sv
// Instruction fetch controller: IDLE/REQ/WAIT/OUT handshake FSM with redirect
// and stale-response drop. Define YSYX_22050039_FETCH_TRACE_EN for a trace.
module ysyx_22050039_fetch_ctrl
   import ysyx_22050039_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   inst_pc,
   input  logic              inst_ready,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic [XLEN-1:0]   pc
);

   fetch_state_e      r_state;
   logic              r_drop;
   logic              r_req_valid;
   logic              r_inst_valid;
   logic [INST_W-1:0] r_inst;
   logic [XLEN-1:0]   r_inst_pc;

   logic              w_req_fire;
   logic              w_accept;
   logic              w_pc_wen;
   logic [XLEN-1:0]   w_pc_din;

   assign w_req_fire = r_req_valid & imem_req_ready;
   assign w_accept   = r_inst_valid & inst_ready;
   // A redirect always wins over the sequential pc+4 step.
   assign w_pc_wen   = redirect_valid | w_accept;
   assign w_pc_din   = redirect_valid ? redirect_pc : pc + XLEN'(4);

   ysyx_22050039_Reg #(
      .WIDTH     (XLEN),
      .RESET_VAL (RESET_PC)
   ) pc_reg (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_wen   (w_pc_wen),
      .i_din   (w_pc_din),
      .o_dout  (pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_drop       <= 1'b0;
         r_req_valid  <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_inst_pc    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state     <= S_REQ;
               r_req_valid <= 1'b1;
            end
            S_REQ: begin
               if (w_req_fire) begin
                  r_state     <= S_WAIT;
                  r_req_valid <= 1'b0;
                  r_drop      <= redirect_valid;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (r_drop | redirect_valid) begin
                     r_drop      <= 1'b0;
                     r_state     <= S_REQ;
                     r_req_valid <= 1'b1;
                  end else begin
                     r_inst       <= imem_rsp_data;
                     r_inst_pc    <= pc;
                     r_state      <= S_OUT;
                     r_inst_valid <= 1'b1;
                  end
               end else if (redirect_valid) begin
                  r_drop <= 1'b1;
               end
            end
            S_OUT: begin
               if (redirect_valid | inst_ready) begin
                  r_state      <= S_REQ;
                  r_inst_valid <= 1'b0;
                  r_req_valid  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef YSYX_22050039_FETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst && w_accept)
         $display("[fetch] accept   pc=%h inst=%h next_pc=%h", inst_pc, inst, w_pc_din);
      if (rst && redirect_valid)
         $display("[fetch] redirect pc=%h inst=%h next_pc=%h", pc, inst, redirect_pc);
   end
`else
   // Trace disabled: no display logic is elaborated.
`endif

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = pc;
   assign inst_valid     = r_inst_valid;
   assign inst           = r_inst;
   assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_ysyx_22050039_fetch_ctrl.sv
// Scoreboard bench: memory/decode driver pushes expected deliveries, a
// negedge monitor compares what the fetch controller offers to decode.
module tb_ysyx_22050039_fetch_ctrl;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [63:0] imem_req_addr;
   logic [31:0] imem_rsp_data, inst;
   logic        inst_valid, inst_ready, redirect_valid;
   logic [63:0] inst_pc, redirect_pc, pc;

   ysyx_22050039_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          total = 0, bad = 0, n_acc = 0;
   logic [63:0] exp_pc;
   bit          outstanding;
   bit          out_kill;
   logic [63:0] out_addr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // Called just after a rising edge: applies inputs for the coming edge and
   // advances the transaction-level model by what that edge will do.
   task automatic drive(input bit rq, input bit rsp, input bit inr, input bit rd,
                        input logic [63:0] tgt, input logic [31:0] d);
      imem_req_ready = rq;
      imem_rsp_valid = rsp;
      imem_rsp_data  = d;
      inst_ready     = inr;
      redirect_valid = rd;
      redirect_pc    = tgt;
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      if (rsp && outstanding) begin
         if (!out_kill && !rd) sb.push_back('{addr: out_addr, data: d});
         outstanding = 0;
      end
      if (imem_req_valid && rq) begin
         outstanding = 1;
         out_addr    = exp_pc;
         out_kill    = rd;
      end else if (outstanding && rd) begin
         out_kill = 1;
      end
      if (rd) exp_pc = tgt;
      else if (inst_valid && inr) exp_pc = exp_pc + 64'd4;
   endtask

   task automatic cyc(input bit rq, input bit rsp, input bit inr, input bit rd,
                      input logic [63:0] tgt, input logic [31:0] d);
      drive(rq, rsp, inr, rd, tgt, d);
      @(posedge clk);
      #1;
   endtask

   task automatic reach_out();
      for (int i = 0; i < 20; i++) begin
         if (inst_valid) return;
         cyc(1, 1, 0, 0, '0, $urandom);
      end
      timeout("reach_out");
   endtask

   task automatic reach_req();
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid) return;
         cyc(0, 1, 1, 0, '0, $urandom);
      end
      timeout("reach_req");
   endtask

   always @(negedge clk) begin
      if (rst && inst_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: inst_valid with inst_pc=%h inst=%h but nothing expected", inst_pc, inst);
         end else begin
            chk("inst", {32'h0, inst}, {32'h0, sb[0].data});
            chk("inst_pc", inst_pc, sb[0].addr);
            if (inst_ready || redirect_valid) begin
               void'(sb.pop_front());
               if (inst_ready) n_acc++;
            end
         end
      end
   end

   initial begin
      int          reqc[$];
      logic [63:0] reqa[$];
      logic [63:0] p;
      rst = 1'b0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
      inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
      outstanding = 0; out_kill = 0; out_addr = '0; exp_pc = RPC;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
      chk("rst_inst_valid", {63'h0, inst_valid}, 64'd0);
      chk("rst_pc", pc, RPC);
      chk("rst_inst", {32'h0, inst}, 64'd0);
      chk("rst_inst_pc", inst_pc, 64'd0);
      rst = 1'b1;

      // Back-to-back fetch with zero-wait memory and decode.
      for (int i = 0; i < 11; i++) begin
         if (imem_req_valid) begin
            reqc.push_back(i);
            reqa.push_back(imem_req_addr);
         end
         cyc(1, 1, 1, 0, '0, 32'h0000_0013);
      end
      if (reqa.size() < 3) timeout("stream_reqs");
      else begin
         chk("stream_a0", reqa[0], 64'h8000_0000);
         chk("stream_a1", reqa[1], 64'h8000_0004);
         chk("stream_a2", reqa[2], 64'h8000_0008);
         chk("stream_gap0", 64'(reqc[1] - reqc[0]), 64'd3);
         chk("stream_gap1", 64'(reqc[2] - reqc[1]), 64'd3);
      end

      // Decode stall in OUT.
      reach_out();
      p = exp_pc;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 0, 0, '0, $urandom);
         chk("stall_no_req", {63'h0, imem_req_valid}, 64'd0);
         chk("stall_valid", {63'h0, inst_valid}, 64'd1);
      end
      cyc(1, 1, 1, 0, '0, $urandom);
      chk("stall_next_addr", imem_req_addr, p + 64'd4);

      // Redirect while waiting; late response must be dropped.
      reach_req();
      cyc(1, 0, 1, 0, '0, '0);
      cyc(0, 0, 0, 1, 64'h8000_1000, '0);
      cyc(0, 1, 0, 0, '0, 32'hDEAD_BEEF);
      chk("drop_no_inst", {63'h0, inst_valid}, 64'd0);
      chk("drop_req_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("drop_addr", imem_req_addr, 64'h8000_1000);

      // Redirect coincident with accept.
      reach_req();
      cyc(0, 0, 0, 1, 64'h8000_0010, '0);
      chk("redir_req_addr", imem_req_addr, 64'h8000_0010);
      reach_out();
      cyc(0, 0, 1, 1, 64'h8000_0100, '0);
      chk("redir_acc_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("redir_acc_addr", imem_req_addr, 64'h8000_0100);

      // PC wrap.
      cyc(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, '0);
      reach_out();
      cyc(0, 0, 1, 0, '0, '0);
      chk("wrap_addr", imem_req_addr, 64'd0);

      // Reset in WAIT, response arrives during and after reset.
      reach_req();
      cyc(1, 0, 0, 0, '0, '0);
      imem_req_ready = 0; inst_ready = 0; redirect_valid = 0;
      imem_rsp_valid = 1; imem_rsp_data = 32'hCAFE_F00D;
      rst = 1'b0;
      sb.delete();
      outstanding = 0; out_kill = 0; exp_pc = RPC;
      #1;
      chk("mid_rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
      chk("mid_rst_inst_valid", {63'h0, inst_valid}, 64'd0);
      chk("mid_rst_pc", pc, RPC);
      chk("mid_rst_inst", {32'h0, inst}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 6 && !imem_req_valid; i++) begin
         chk("post_rst_no_inst", {63'h0, inst_valid}, 64'd0);
         cyc(0, 1, 0, 0, '0, 32'hCAFE_F00D);
      end
      chk("post_rst_addr", imem_req_addr, RPC);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         logic [63:0] t;
         t = {$urandom, $urandom} & ~64'h3;
         if ($urandom_range(0, 3) == 0) t = 64'h8000_0000 + 64'($urandom_range(0, 255) << 2);
         cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), t, $urandom);
      end

      // Drain and settle in REQ with nothing in flight.
      repeat (6) cyc(1, 1, 1, 0, '0, $urandom);
      reach_req();
      chk("drain_sb_empty", 64'(sb.size()), 64'd0);
      chk("progress", {63'h0, (n_acc >= 40)}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
